// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared definitions for the multiply/divide unit and the ID
// decoder. It provides the op-code constants driven on in_op, the default
// operand width, and the FSM state type.
package ex_muldiv_pkg;

   localparam int unsigned MD_WIDTH = 32;

   localparam logic [2:0] MD_MULT  = 3'b000;
   localparam logic [2:0] MD_MULTU = 3'b001;
   localparam logic [2:0] MD_DIV   = 3'b010;
   localparam logic [2:0] MD_DIVU  = 3'b011;
   localparam logic [2:0] MD_MTHI  = 3'b100;
   localparam logic [2:0] MD_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2
   } md_state_t;

   // MULT/MULTU/DIV/DIVU all have op[2] clear.
   function automatic logic md_is_iterative(input logic [2:0] op);
      return ~op[2];
   endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter: one combinational radix-2 step of the multi-cycle
// multiply/divide datapath.
//   is_div   : 1 = restoring shift-subtract step, 0 = shift-add step
//   hi_in    : multiply: upper product half / divide: partial remainder
//   lo_in    : multiply: lower product half with unconsumed multiplier bits
//              divide: dividend bits still to shift in, with quotient bits
//              filling from the bottom
//   operand  : multiplicand or divisor (magnitude)
//   hi_out/lo_out : register values after this step
module ex_muldiv_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] hi_in,
   input  logic [WIDTH-1:0] lo_in,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic           take;

   always_comb begin
      sum     = {1'b0, hi_in} + ({(WIDTH+1){lo_in[0]}} & {1'b0, operand});
      shifted = {hi_in, lo_in[WIDTH-1]};
      // The shifted remainder can exceed WIDTH bits only when it is already
      // larger than any divisor, so its top bit forces a subtract.
      take    = shifted[WIDTH] || (shifted[WIDTH-1:0] >= operand);
      hi_out  = sum[WIDTH:1];
      lo_out  = {sum[0], lo_in[WIDTH-1:1]};
      if (is_div) begin
         hi_out = take ? (shifted[WIDTH-1:0] - operand) : shifted[WIDTH-1:0];
         lo_out = {lo_in[WIDTH-2:0], take};
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit beside the EX-stage ALU. It
// executes MULT/MULTU/DIV/DIVU in 33 cycles, performs MTHI/MTLO in a single
// cycle, and owns the architectural HI/LO registers.
//   in_clk, in_rst       : rising-edge clock, asynchronous active-high reset
//   in_start, in_op      : request strobe and op code, sampled only in IDLE
//   in_dataA, in_dataB   : rs / rt operands
//   in_cancel            : pipeline flush; aborts an in-flight op and drops
//                          a start presented in the same cycle
//   out_busy             : op in flight (state != IDLE)
//   out_done             : one-cycle pulse after HI/LO were written by MULT/DIV
//   out_hi, out_lo       : HI/LO registers, with no bypass
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH,
   parameter int unsigned CNT_W = 6
) (
   input  logic             in_clk,
   input  logic             in_rst,
   input  logic             in_start,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_dataA,
   input  logic [WIDTH-1:0] in_dataB,
   input  logic             in_cancel,
   output logic             out_busy,
   output logic             out_done,
   output logic [WIDTH-1:0] out_hi,
   output logic [WIDTH-1:0] out_lo
);

   md_state_t          state, next_state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;
   logic [WIDTH-1:0]   it_hi, it_lo;
   logic               is_div, neg_res, neg_rem;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               done_q;

   logic               load, finish, wr_hi, wr_lo;
   logic               op_signed;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [2*WIDTH-1:0] prod_mag, prod_res;
   logic [WIDTH-1:0]   res_hi, res_lo;

   // Magnitudes of signed operands; the most negative value maps onto its
   // unsigned magnitude without any special case.
   always_comb begin
      op_signed = ~in_op[0];
      mag_a     = (op_signed && in_dataA[WIDTH-1]) ? -in_dataA : in_dataA;
      mag_b     = (op_signed && in_dataB[WIDTH-1]) ? -in_dataB : in_dataB;
   end

   ex_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .is_div  (is_div),
      .hi_in   (acc_hi),
      .lo_in   (acc_lo),
      .operand (opnd),
      .hi_out  (it_hi),
      .lo_out  (it_lo)
   );

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      load       = 1'b0;
      finish     = 1'b0;
      wr_hi      = 1'b0;
      wr_lo      = 1'b0;
      case (state)
         IDLE: begin
            if (in_start && !in_cancel) begin
               if (md_is_iterative(in_op)) begin
                  load       = 1'b1;
                  next_state = CALC;
               end else begin
                  wr_hi = (in_op == MD_MTHI);
                  wr_lo = (in_op == MD_MTLO);
               end
            end
         end
         CALC: begin
            if (in_cancel)                       next_state = IDLE;
            else if (cnt == CNT_W'(WIDTH - 1))   next_state = SIGN;
         end
         SIGN: begin
            next_state = IDLE;
            finish     = !in_cancel;
         end
         default: next_state = IDLE;
      endcase
   end

   // Both operations share acc_hi/acc_lo: the dividend (or multiplier) is
   // loaded into acc_lo and consumed one bit per step.
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         cnt     <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         opnd    <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
      end else if (load) begin
         cnt     <= '0;
         acc_hi  <= '0;
         acc_lo  <= mag_a;
         opnd    <= mag_b;
         is_div  <= in_op[1];
         neg_res <= op_signed & (in_dataA[WIDTH-1] ^ in_dataB[WIDTH-1]);
         neg_rem <= op_signed & in_dataA[WIDTH-1];
      end else if (state == CALC) begin
         acc_hi  <= it_hi;
         acc_lo  <= it_lo;
         cnt     <= cnt + 1'b1;
      end
   end

   always_comb begin
      prod_mag = {acc_hi, acc_lo};
      prod_res = neg_res ? -prod_mag : prod_mag;
      res_hi   = prod_res[2*WIDTH-1:WIDTH];
      res_lo   = prod_res[WIDTH-1:0];
      if (is_div) begin
         res_hi = neg_rem ? -acc_hi : acc_hi;
         res_lo = neg_res ? -acc_lo : acc_lo;
      end
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= finish;
         if (wr_hi) hi_q <= in_dataA;
         if (wr_lo) lo_q <= in_dataA;
         if (finish) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
         end
      end
   end

   assign out_busy = (state != IDLE);
   assign out_done = done_q;
   assign out_hi   = hi_q;
   assign out_lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed-vector bench for ex_muldiv with hand-computed
// expected HI/LO values, latency and busy/done timing.
module tb_ex_muldiv;

   localparam int unsigned W = 32;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [2:0] OP_NOP   = 3'b110;

   logic         in_clk = 1'b0;
   logic         in_rst;
   logic         in_start;
   logic [2:0]   in_op;
   logic [W-1:0] in_dataA;
   logic [W-1:0] in_dataB;
   logic         in_cancel;
   logic         out_busy;
   logic         out_done;
   logic [W-1:0] out_hi;
   logic [W-1:0] out_lo;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 in_clk = ~in_clk;

   ex_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
      .in_clk    (in_clk),
      .in_rst    (in_rst),
      .in_start  (in_start),
      .in_op     (in_op),
      .in_dataA  (in_dataA),
      .in_dataB  (in_dataB),
      .in_cancel (in_cancel),
      .out_busy  (out_busy),
      .out_done  (out_done),
      .out_hi    (out_hi),
      .out_lo    (out_lo)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Issue one op at the next rising edge (e0) and follow it until out_done
   // or a 40-cycle budget. inj=1 presents a MULT start sampled at edge 5;
   // inj=2 asserts in_cancel for edge 10.
   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inj, output int cycles, output int busy_cnt, output bit saw_done);
      @(negedge in_clk);
      in_start = 1'b1; in_op = op; in_dataA = a; in_dataB = b;
      @(posedge in_clk); #1;
      in_start = 1'b0;
      cycles   = 0;
      busy_cnt = out_busy ? 1 : 0;
      saw_done = 1'b0;
      while (!saw_done && cycles < 40) begin
         @(negedge in_clk);
         if (inj == 1 && cycles == 4) begin
            in_start = 1'b1; in_op = OP_MULT; in_dataA = 32'd3; in_dataB = 32'd3;
         end
         in_cancel = (inj == 2 && cycles == 9);
         @(posedge in_clk); #1;
         cycles++;
         in_start  = 1'b0;
         in_cancel = 1'b0;
         if (out_done)      saw_done = 1'b1;
         else if (out_busy) busy_cnt++;
      end
   endtask

   task automatic expect_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input int inj,
                            input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
      int cycles, busy_cnt;
      bit saw_done;
      run_op(op, a, b, inj, cycles, busy_cnt, saw_done);
      check({tag, " latency"}, cycles, 33);
      check({tag, " busy_cycles"}, busy_cnt, 33);
      check({tag, " busy_in_done"}, out_busy, 0);
      check({tag, " hi"}, out_hi, exp_hi);
      check({tag, " lo"}, out_lo, exp_lo);
      @(posedge in_clk); #1;
      check({tag, " done_pulse_end"}, out_done, 0);
   endtask

   initial begin
      int cycles, busy_cnt;
      bit saw_done;

      in_rst = 1'b1; in_start = 1'b0; in_op = '0;
      in_dataA = '0; in_dataB = '0; in_cancel = 1'b0;
      repeat (2) @(posedge in_clk);
      #1;
      check("reset busy", out_busy, 0);
      check("reset done", out_done, 0);
      check("reset hi", out_hi, 0);
      check("reset lo", out_lo, 0);
      @(negedge in_clk);
      in_rst = 1'b0;

      expect_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h0000_0001);
      expect_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      expect_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      expect_op("divu_zero", OP_DIVU,  32'h0000_0064, 32'h0000_0000, 0, 32'h0000_0064, 32'hFFFF_FFFF);
      expect_op("div_zero_neg", OP_DIV, 32'hFFFF_FF9C, 32'h0000_0000, 0, 32'hFFFF_FF9C, 32'h0000_0001);
      expect_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0000_0000, 32'h8000_0000);

      // MTHI then MTLO on consecutive edges
      @(negedge in_clk);
      in_start = 1'b1; in_op = OP_MTHI; in_dataA = 32'h1234_5678;
      @(posedge in_clk); #1;
      check("mthi hi", out_hi, 32'h1234_5678);
      check("mthi busy", out_busy, 0);
      @(negedge in_clk);
      in_op = OP_MTLO; in_dataA = 32'h9ABC_DEF0;
      @(posedge in_clk); #1;
      in_start = 1'b0;
      check("mtlo lo", out_lo, 32'h9ABC_DEF0);
      check("mtlo hi_kept", out_hi, 32'h1234_5678);
      check("mtlo busy", out_busy, 0);
      check("mtlo done", out_done, 0);

      // Reserved op code is ignored
      @(negedge in_clk);
      in_start = 1'b1; in_op = OP_NOP; in_dataA = 32'hDEAD_BEEF;
      @(posedge in_clk); #1;
      in_start = 1'b0;
      check("nop busy", out_busy, 0);
      check("nop hi", out_hi, 32'h1234_5678);
      check("nop lo", out_lo, 32'h9ABC_DEF0);

      // Start with cancel in IDLE is dropped
      @(negedge in_clk);
      in_start = 1'b1; in_cancel = 1'b1; in_op = OP_MTHI; in_dataA = 32'hCAFE_F00D;
      @(posedge in_clk); #1;
      in_start = 1'b0; in_cancel = 1'b0;
      check("cancel_idle hi", out_hi, 32'h1234_5678);
      check("cancel_idle busy", out_busy, 0);

      expect_op("divu_extra_start", OP_DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14);

      // Cancel at edge 10: back to IDLE, HI/LO keep 2/14, no done
      run_op(OP_DIVU, 32'd1000, 32'd3, 2, cycles, busy_cnt, saw_done);
      check("cancel done_seen", saw_done, 0);
      check("cancel busy_cycles", busy_cnt, 10);
      check("cancel busy", out_busy, 0);
      check("cancel hi", out_hi, 32'd2);
      check("cancel lo", out_lo, 32'd14);

      // Asynchronous reset during a MULT, between edges 20 and 21
      @(negedge in_clk);
      in_start = 1'b1; in_op = OP_MULT; in_dataA = 32'h0000_1234; in_dataB = 32'h0000_5678;
      @(posedge in_clk); #1;
      in_start = 1'b0;
      repeat (20) @(posedge in_clk);
      #3;
      in_rst = 1'b1;
      #1;
      check("async_rst busy", out_busy, 0);
      check("async_rst done", out_done, 0);
      check("async_rst hi", out_hi, 0);
      check("async_rst lo", out_lo, 0);
      @(negedge in_clk);
      in_rst = 1'b0;

      expect_op("multu_after_rst", OP_MULTU, 32'd3, 32'd5, 0, 32'd0, 32'd15);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
